// File: rtl/threebit_pkg.sv
// rtl/threebit_pkg.sv - shared types and constants for the three-bit counter family
package threebit_pkg;

   localparam int DEFAULT_WIDTH  = 3;
   localparam int DEFAULT_FIRE_W = 3;

   localparam int FIRE_UNDERFLOW = 0;
   localparam int FIRE_CONFLICT  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/threebit_underflow_check.sv
// rtl/threebit_underflow_check.sv - registered underflow / load-decrement conflict checker
module threebit_underflow_check
   import threebit_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int FIRE_W = DEFAULT_FIRE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  state_t            state,
   input  logic [WIDTH-1:0]  data_out,
   input  logic              ld,
   input  logic              dec,
   input  logic              auto_reload,
   input  logic              reload_zero,
   output logic [FIRE_W-1:0] fire
);

   logic [FIRE_W-1:0] r_fire;
   logic [FIRE_W-1:0] w_fire_next;
   logic              w_reload_ok;

   // A decrement at zero is legal only when DONE can reload a non-zero value.
   assign w_reload_ok = (state == DONE) && auto_reload && !reload_zero;

   always_comb begin
      w_fire_next                 = '0;
      w_fire_next[FIRE_UNDERFLOW] = !ld && dec && (data_out == '0) && !w_reload_ok;
      w_fire_next[FIRE_CONFLICT]  = ld && dec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fire <= '0;
      end else begin
         r_fire <= w_fire_next;
      end
   end

   assign fire = r_fire;

endmodule

// File: rtl/threebit_downcounter.sv
// rtl/threebit_downcounter.sv - loadable down-counter with terminal count and auto-reload
module threebit_downcounter
   import threebit_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int FIRE_W = DEFAULT_FIRE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             dec,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             zero,
   output logic             tc,
   output logic             busy,
   output logic             assert_fire
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_count;
   logic [WIDTH-1:0]  w_count_next;
   logic [WIDTH-1:0]  r_reload;
   logic [WIDTH-1:0]  w_reload_next;
   logic              r_zero;
   logic              r_tc;
   logic              w_tc_next;
   logic [FIRE_W-1:0] w_fire;

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_reload_next = r_reload;
      w_tc_next     = 1'b0;
      if (ld) begin
         w_count_next  = data_in;
         w_reload_next = data_in;
         w_state_next  = (data_in != '0) ? RUN : DONE;
      end else if (dec) begin
         case (r_state)
            RUN: begin
               if (r_count > ONE) begin
                  w_count_next = r_count - ONE;
               end else begin
                  w_count_next = '0;
                  w_state_next = DONE;
                  w_tc_next    = (r_count == ONE);
               end
            end
            DONE: begin
               if (auto_reload && (r_reload != '0)) begin
                  w_count_next = r_reload;
                  w_state_next = RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_zero   <= 1'b1;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_count  <= w_count_next;
         r_reload <= w_reload_next;
         r_zero   <= (w_count_next == '0);
         r_tc     <= w_tc_next;
      end
   end

   threebit_underflow_check #(
      .WIDTH  (WIDTH),
      .FIRE_W (FIRE_W)
   ) u_check (
      .clk         (clk),
      .rst         (rst),
      .state       (r_state),
      .data_out    (r_count),
      .ld          (ld),
      .dec         (dec),
      .auto_reload (auto_reload),
      .reload_zero (r_reload == '0),
      .fire        (w_fire)
   );

   assign data_out    = r_count;
   assign zero        = r_zero;
   assign tc          = r_tc;
   assign busy        = (r_state == RUN);
   // Reserved fire bits are tied low, so reducing the whole vector is safe.
   assign assert_fire = |w_fire;

endmodule

// File: tb/tb_threebit_downcounter.sv
// tb/tb_threebit_downcounter.sv - directed self-checking bench for threebit_downcounter
module tb_threebit_downcounter;
   import threebit_pkg::*;

   logic       clk;
   logic       rst;
   logic       ld;
   logic       dec;
   logic       auto_reload;
   logic [2:0] data_in;
   logic [2:0] data_out;
   logic       zero;
   logic       tc;
   logic       busy;
   logic       assert_fire;

   int checks;
   int errors;

   threebit_downcounter dut (
      .clk         (clk),
      .rst         (rst),
      .ld          (ld),
      .dec         (dec),
      .auto_reload (auto_reload),
      .data_in     (data_in),
      .data_out    (data_out),
      .zero        (zero),
      .tc          (tc),
      .busy        (busy),
      .assert_fire (assert_fire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; ld = 1'b0; dec = 1'b0; auto_reload = 1'b0; data_in = 3'd0;
      step();
      checks++; if (data_out !== 3'd0) begin errors++; $display("FAIL reset_data_out got %0d exp 0", data_out); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (assert_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %b exp 0", assert_fire); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_idle_dec();
      logic [2:0] exp_d [2];
      logic       exp_f [2];
      exp_d = '{3'd0, 3'd0};
      exp_f = '{1'b1, 1'b0};
      dec = 1'b1; auto_reload = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         dec = 1'b0;
         checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL idle_dec_data[%0d] got %0d exp %0d", i, data_out, exp_d[i]); end
         checks++; if (assert_fire !== exp_f[i]) begin errors++; $display("FAIL idle_dec_fire[%0d] got %b exp %b", i, assert_fire, exp_f[i]); end
         checks++; if (tc !== 1'b0) begin errors++; $display("FAIL idle_dec_tc[%0d] got %b exp 0", i, tc); end
         checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL idle_dec_state[%0d] got %0d exp %0d", i, dut.r_state, IDLE); end
      end
      auto_reload = 1'b0;
   endtask

   task automatic test_countdown();
      logic [2:0] exp_d [4];
      logic       exp_tc [4];
      logic       exp_busy [4];
      logic       exp_zero [4];
      exp_d    = '{3'd3, 3'd2, 3'd1, 3'd0};
      exp_tc   = '{1'b0, 1'b0, 1'b0, 1'b1};
      exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_zero = '{1'b0, 1'b0, 1'b0, 1'b1};
      ld = 1'b1; data_in = 3'd3;
      for (int i = 0; i < 4; i++) begin
         step();
         ld = 1'b0; dec = 1'b1;
         if (i == 3) dec = 1'b0;
         checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL cd_data[%0d] got %0d exp %0d", i, data_out, exp_d[i]); end
         checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL cd_tc[%0d] got %b exp %b", i, tc, exp_tc[i]); end
         checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL cd_busy[%0d] got %b exp %b", i, busy, exp_busy[i]); end
         checks++; if (zero !== exp_zero[i]) begin errors++; $display("FAIL cd_zero[%0d] got %b exp %b", i, zero, exp_zero[i]); end
         checks++; if (assert_fire !== 1'b0) begin errors++; $display("FAIL cd_fire[%0d] got %b exp 0", i, assert_fire); end
      end
   endtask

   task automatic test_underflow();
      logic exp_f [3];
      exp_f = '{1'b1, 1'b1, 1'b0};
      auto_reload = 1'b0; dec = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 1) dec = 1'b0;
         checks++; if (data_out !== 3'd0) begin errors++; $display("FAIL uf_data[%0d] got %0d exp 0", i, data_out); end
         checks++; if (assert_fire !== exp_f[i]) begin errors++; $display("FAIL uf_fire[%0d] got %b exp %b", i, assert_fire, exp_f[i]); end
         checks++; if (tc !== 1'b0) begin errors++; $display("FAIL uf_tc[%0d] got %b exp 0", i, tc); end
         checks++; if (zero !== 1'b1) begin errors++; $display("FAIL uf_zero[%0d] got %b exp 1", i, zero); end
      end
   endtask

   task automatic test_auto_reload();
      logic [2:0] exp_d [5];
      logic       exp_tc [5];
      logic       exp_busy [5];
      exp_d    = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd1};
      exp_tc   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ld = 1'b1; data_in = 3'd2; auto_reload = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         ld = 1'b0; dec = (i < 4);
         checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL ar_data[%0d] got %0d exp %0d", i, data_out, exp_d[i]); end
         checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL ar_tc[%0d] got %b exp %b", i, tc, exp_tc[i]); end
         checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL ar_busy[%0d] got %b exp %b", i, busy, exp_busy[i]); end
         checks++; if (assert_fire !== 1'b0) begin errors++; $display("FAIL ar_fire[%0d] got %b exp 0", i, assert_fire); end
      end
      dec = 1'b0; auto_reload = 1'b0;
   endtask

   task automatic test_conflict();
      ld = 1'b1; dec = 1'b1; data_in = 3'd7;
      step();
      ld = 1'b0; dec = 1'b0;
      checks++; if (data_out !== 3'd7) begin errors++; $display("FAIL conf_data got %0d exp 7", data_out); end
      checks++; if (assert_fire !== 1'b1) begin errors++; $display("FAIL conf_fire got %b exp 1", assert_fire); end
      checks++; if (dut.u_check.fire[FIRE_CONFLICT] !== 1'b1) begin errors++; $display("FAIL conf_bit1 got %b exp 1", dut.u_check.fire[FIRE_CONFLICT]); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL conf_tc got %b exp 0", tc); end
      step();
      checks++; if (assert_fire !== 1'b0) begin errors++; $display("FAIL conf_fire_clear got %b exp 0", assert_fire); end
      checks++; if (data_out !== 3'd7) begin errors++; $display("FAIL conf_hold got %0d exp 7", data_out); end
   endtask

   task automatic test_zero_load();
      ld = 1'b1; data_in = 3'd0;
      step();
      ld = 1'b0;
      checks++; if (data_out !== 3'd0) begin errors++; $display("FAIL zl_data got %0d exp 0", data_out); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zl_zero got %b exp 1", zero); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL zl_tc got %b exp 0", tc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zl_busy got %b exp 0", busy); end
      checks++; if (dut.r_state !== DONE) begin errors++; $display("FAIL zl_state got %0d exp %0d", dut.r_state, DONE); end
   endtask

   task automatic test_async_reset();
      ld = 1'b1; dec = 1'b1; data_in = 3'd5;
      step();
      ld = 1'b0; dec = 1'b0;
      checks++; if (data_out !== 3'd5) begin errors++; $display("FAIL ar_pre_data got %0d exp 5", data_out); end
      checks++; if (assert_fire !== 1'b1) begin errors++; $display("FAIL ar_pre_fire got %b exp 1", assert_fire); end
      #2 rst = 1'b0;
      #1;
      checks++; if (data_out !== 3'd0) begin errors++; $display("FAIL async_data got %0d exp 0", data_out); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL async_zero got %b exp 1", zero); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", busy); end
      checks++; if (assert_fire !== 1'b0) begin errors++; $display("FAIL async_fire got %b exp 0", assert_fire); end
      step();
      rst = 1'b1;
      step();
      checks++; if (dut.r_reload !== 3'd0) begin errors++; $display("FAIL async_reload got %0d exp 0", dut.r_reload); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_idle_dec();
      test_countdown();
      test_underflow();
      test_auto_reload();
      test_conflict();
      test_zero_load();
      test_async_reset();
      test_idle_dec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/threebit_downcounter.md
Name: threebit_downcounter

Overview:
Loadable down-counter. It is the consuming end of the three-bit counter interface: it drains a count that the up-counter side produces, instead of accumulating one.
- Reports terminal count and supports optional auto-reload.
- Carries an in-line underflow/conflict checker whose fire vector is exported as assert_fire, like the overflow check on the up-counter.
- Sits beside the threebitcounter as the credit/timer consumer.

Parameters:
WIDTH, 3, counter and data_in width
FIRE_W, 3, width of internal checker fire vector (bit0 underflow, bit1 ld/dec conflict, bit2 reserved 0)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
ld  input  1  load data_in into count and reload register
dec  input  1  decrement request
auto_reload  input  1  when 1, dec at zero reloads from reload register instead of underflowing
data_in  input  WIDTH  load value
data_out  output reg  WIDTH  current count
zero  output  1  registered; 1 when data_out==0
tc  output  1  registered one-cycle pulse when count transitions to zero via dec
busy  output  1  1 while state==RUN
assert_fire  output wire  1  OR of fire[1:0], registered one-cycle pulse per violating cycle

Behaviour:
- Reset asserted (rst==0, async): data_out=0, reload_reg=0, zero=1, tc=0, fire=0, assert_fire=0, state=IDLE.
- Reset release: first update on the next rising clk edge. Reset mid-count discards count and reload_reg.
- Priority: ld over dec. ld && dec in the same cycle:
  - load wins, dec is dropped;
  - fire[1] pulses the following cycle.
- ld, any state:
  - data_out<=data_in, reload_reg<=data_in;
  - next state RUN if data_in!=0, else DONE;
  - no tc.
- States:
  - IDLE: no load since reset. dec -> underflow (fire[0]), data_out stays 0, stay IDLE, even if auto_reload=1 (reload_reg=0).
  - RUN: dec with data_out>1 -> data_out-1, stay RUN. dec with data_out==1 -> data_out=0, tc=1 next cycle, go DONE.
  - DONE: dec && auto_reload && reload_reg!=0 -> data_out<=reload_reg, go RUN, no fire, no tc. dec otherwise -> underflow, fire[0] pulse, data_out stays 0, stay DONE.
- Arithmetic is unsigned WIDTH-bit. No wrap from 0 to 2^WIDTH-1 ever occurs; underflow saturates at 0 and is flagged.
- Output timing:
  - zero, busy and tc are registered, consistent with data_out in the same cycle.
  - tc is high for exactly one cycle.
- Checker output:
  - fire is registered; each bit is a single-cycle pulse per violating cycle.
  - Back-to-back violations give consecutive pulses.
  - assert_fire = fire[0] | fire[1]. fire[2] is tied 0.
- Latency: one cycle from ld/dec sample to data_out/zero/tc/fire update.
- No display or simulation-only side effects are required. Any $display on reset is wrapped in synthesis translate_off/on.

Decomposition:
- Shared package threebit_pkg:
  - state typedef (IDLE, RUN, DONE, 2-bit encoding);
  - fire bit index constants (FIRE_UNDERFLOW=0, FIRE_CONFLICT=1);
  - default WIDTH.
- One sub-module, threebit_underflow_check:
  - inputs: clk, rst, state, data_out, ld, dec, auto_reload, reload_zero;
  - output: fire[FIRE_W-1:0], registered.
  - It is the counterpart of the overflow check and can later be replaced by an OVL instance.
- Counter datapath and FSM stay in threebit_downcounter.

Test Plan:
- Reset: drive rst=0 mid-run with data_out=5 -> data_out=0, zero=1, busy=0, assert_fire=0 immediately, without waiting for a clk edge.
- Countdown: ld with data_in=3, then dec x3 -> data_out 3,2,1,0; tc=1 only in the cycle data_out becomes 0; busy drops with it; assert_fire stays 0.
- Underflow: after reaching 0 with auto_reload=0, dec x2 -> data_out stays 0; assert_fire pulses two consecutive cycles; tc stays 0.
- Auto-reload: ld with data_in=2, auto_reload=1, dec x4 -> data_out 2,1,0,2,1; tc once at the first 0; no fire.
- Conflict and zero load:
  - ld with data_in=7 together with dec -> data_out=7, fire[1]/assert_fire pulse one cycle later.
  - ld with data_in=0 -> state DONE, zero=1, tc=0.
- IDLE dec: after reset, dec with auto_reload=1 -> underflow fire pulse, data_out=0, state stays IDLE.
